mem_arbiter: RTL

Two-master arbiter in front of the single external-SRAM memory port. It merges the CPU memory port with a read-only VGA scan-out master onto one downstream port that feeds the SRAM controller (or blockram in simulation). The arbiter adds no latency on the granted path and routes returned read data by transaction id. VGA normally has priority, and a run-length limit guarantees CPU forward progress.

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 73 +++++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-port definitions for the SRAM arbiter.
// Holds bus widths, id constants and the forwarded request bundle.
package mem_arbiter_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int ID_W   = 2;

    localparam logic [ID_W-1:0] ID_NONE     = 2'd0;
    localparam logic [ID_W-1:0] VGA_ID_DFLT = 2'd3;

    localparam int VGA_MAX_RUN_DFLT = 8;

    typedef enum logic {
        OWN_CPU,
        OWN_VGA
    } owner_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CPU,
        SEL_VGA
    } sel_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] address;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] writedata;
        logic [MASK_W-1:0] writedatamask;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus interfaces for the CPU port, the VGA scan-out port
// and the downstream SRAM port of the arbiter.
interface mem_arbiter_cpu_if;
    import mem_arbiter_pkg::*;

    logic              waitrequest;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [MASK_W-1:0] writedatamask;
    logic [DATA_W-1:0] readdata;
    logic [ID_W-1:0]   readdataid;

    modport master (
        output id, address, read, write,
        output writedata, writedatamask,
        input  waitrequest, readdata, readdataid
    );

    modport slave (
        input  id, address, read, write,
        input  writedata, writedatamask,
        output waitrequest, readdata, readdataid
    );
endinterface

interface mem_arbiter_vga_if;
    import mem_arbiter_pkg::*;

    logic              waitrequest;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

interface mem_arbiter_mem_if;
    import mem_arbiter_pkg::*;

    logic              waitrequest;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [MASK_W-1:0] writedatamask;
    logic [DATA_W-1:0] readdata;
    logic [ID_W-1:0]   readdataid;

    modport master (
        output id, address, read, write,
        output writedata, writedatamask,
        input  waitrequest, readdata, readdataid
    );

    modport slave (
        input  id, address, read, write,
        input  writedata, writedatamask,
        output waitrequest, readdata, readdataid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master SRAM arbiter: VGA scan-out has priority, the CPU is
// guaranteed a slot after VGA_MAX_RUN back-to-back VGA transfers.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [ID_W-1:0] VGA_ID      = VGA_ID_DFLT,
    parameter int              VGA_MAX_RUN = VGA_MAX_RUN_DFLT
) (
    input  logic              clock,
    input  logic              rst,
    mem_arbiter_cpu_if.slave  cpu,
    mem_arbiter_vga_if.slave  vga,
    mem_arbiter_mem_if.master mem
);

    localparam int RUN_W = $clog2(VGA_MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VGA_MAX_RUN);

    logic             lock;
    logic             lock_n;
    owner_e           owner;
    owner_e           owner_n;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_n;

    sel_e     sel;
    mem_req_t req;
    logic     cpu_req;
    logic     run_full;
    logic     sel_live;
    logic     cpu_acc;
    logic     vga_acc;
    logic     cpu_wait;
    logic     vga_wait;

    logic            rid_vga;
    logic            rid_cpu;
    logic [ID_W-1:0] cpu_rid;
    logic            vga_rvalid;

    assign cpu_req  = cpu.read | cpu.write;
    assign run_full = (run_cnt == RUN_MAX) && cpu_req;

    always_ff @(posedge clock) begin
        if (rst) begin
            lock    <= 1'b0;
            owner   <= OWN_CPU;
            run_cnt <= '0;
        end else begin
            lock    <= lock_n;
            owner   <= owner_n;
            run_cnt <= run_cnt_n;
        end
    end

    // A stalled grant is pinned to its owner until it is accepted.
    always_comb begin
        sel = SEL_NONE;
        if (rst) begin
            sel = SEL_NONE;
        end else if (lock) begin
            sel = (owner == OWN_VGA) ? SEL_VGA : SEL_CPU;
        end else if (vga.read && !run_full) begin
            sel = SEL_VGA;
        end else if (cpu_req) begin
            sel = SEL_CPU;
        end
    end

    always_comb begin
        req      = '0;
        req.id   = ID_NONE;
        cpu_wait = 1'b1;
        vga_wait = 1'b1;
        sel_live = 1'b0;
        unique case (sel)
            SEL_CPU: begin
                req.id            = cpu.id;
                req.address       = cpu.address;
                req.read          = cpu.read;
                req.write         = cpu.write;
                req.writedata     = cpu.writedata;
                req.writedatamask = cpu.writedatamask;
                cpu_wait          = mem.waitrequest;
                sel_live          = cpu_req;
            end
            SEL_VGA: begin
                req.id      = VGA_ID;
                req.address = vga.address;
                req.read    = 1'b1;
                vga_wait    = mem.waitrequest;
                sel_live    = vga.read;
            end
            default: ;
        endcase
    end

    assign cpu_acc = (sel == SEL_CPU) && cpu_req && !mem.waitrequest;
    assign vga_acc = (sel == SEL_VGA) && vga.read && !mem.waitrequest;

    always_comb begin
        lock_n    = sel_live && mem.waitrequest;
        owner_n   = owner;
        run_cnt_n = run_cnt;
        unique case (sel)
            SEL_CPU: owner_n = OWN_CPU;
            SEL_VGA: owner_n = OWN_VGA;
            default: ;
        endcase
        if (cpu_acc || !cpu_req) begin
            run_cnt_n = '0;
        end else if (vga_acc && run_cnt != RUN_MAX) begin
            run_cnt_n = run_cnt + RUN_W'(1);
        end
    end

    assign mem.id            = req.id;
    assign mem.address       = req.address;
    assign mem.read          = req.read;
    assign mem.write         = req.write;
    assign mem.writedata     = req.writedata;
    assign mem.writedatamask = req.writedatamask;

    assign cpu.waitrequest = cpu_wait;
    assign vga.waitrequest = vga_wait;

    // Returns are steered purely by id, independent of the grant.
    assign rid_vga = (mem.readdataid == VGA_ID);
    assign rid_cpu = !rid_vga && (mem.readdataid != ID_NONE);

    always_comb begin
        cpu_rid    = ID_NONE;
        vga_rvalid = 1'b0;
        if (!rst) begin
            unique case (1'b1)
                rid_vga: vga_rvalid = 1'b1;
                rid_cpu: cpu_rid    = mem.readdataid;
                default: ;
            endcase
        end
    end

    assign cpu.readdata      = mem.readdata;
    assign cpu.readdataid    = cpu_rid;
    assign vga.readdata      = mem.readdata;
    assign vga.readdatavalid = vga_rvalid;

    a_cpu_id_not_vga: assert property (
        @(posedge clock) disable iff (rst)
        cpu_req |-> (cpu.id != VGA_ID)
    );

endmodule
